// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - run/pause sequencer producing rate-limited enable and direction for the cnt_nb counter
// Optional single-step support: define CNT_SEQ_CTRL_STEP_EN
module cnt_seq_ctrl #(
  parameter int  MAX      = 15,
  parameter int  MIN      = 0,
  parameter int  BASE_DIV = 4,
  localparam int CW       = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic          btn_start,
  input  logic          btn_dir,
  input  logic          btn_step,
  input  logic [1:0]    mode,
  input  logic [1:0]    rate_sel,
  input  logic [CW-1:0] cnt_in,
  output logic          cnt_enable,
  output logic          cnt_u_d,
  output logic          running,
  output logic          done
);

  // Prescaler must reach BASE_DIV*8-1 at the slowest rate
  localparam int            PW    = $clog2(BASE_DIV * 8);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);
  localparam logic [CW-1:0] MIN_V = CW'(MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    rate_q;
  logic [1:0]    guard;
  logic          pending;

  logic [PW-1:0] lim_m1;
  logic          tick;
  logic          at_lim;
  logic          eval_ok;
  logic          trig;
  logic          eval;
  logic          blocked;
  logic          do_eval;
  logic          flip;
  logic          stop;
  logic          fire;
  logic          restart;

`ifndef CNT_SEQ_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = btn_step;
`endif

  // Tick detection and limit evaluation; out-of-range values fall on the limit side of >=/<=
  always_comb begin
    lim_m1  = PW'((BASE_DIV << rate_q) - 1);
    tick    = (state == S_RUN) && (presc == lim_m1);
    at_lim  = cnt_u_d ? (cnt_in <= MIN_V) : (cnt_in >= MAX_V);
`ifdef CNT_SEQ_CTRL_STEP_EN
    eval_ok = (state != S_DONE);
    trig    = pending || ((state == S_RUN) ? tick : btn_step);
`else
    eval_ok = (state == S_RUN);
    trig    = pending || tick;
`endif
    // A start press this cycle changes state, so no evaluation happens alongside it
    eval    = eval_ok && !btn_start && trig;
    // Hold the request while the counter's late U_D copy settles or an enable is still out
    blocked = (guard != 2'd0) || cnt_enable;
    do_eval = eval && !blocked;
    flip    = do_eval && (mode == 2'b01) && at_lim;
    stop    = do_eval && (mode == 2'b10) && at_lim;
    fire    = do_eval && !flip && !stop;
    restart = (state == S_DONE) && btn_start;
  end

  // Sequencer state, prescaler, direction guard and registered outputs
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      presc      <= '0;
      rate_q     <= 2'd0;
      guard      <= 2'd0;
      pending    <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_u_d    <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt_enable <= fire;

      // Bounce flip wins over a direction press in the same cycle
      if (flip) begin
        cnt_u_d <= ~cnt_u_d;
        guard   <= 2'd2;
      end else if (btn_dir || restart) begin
        cnt_u_d <= cnt_u_d ^ btn_dir ^ restart;
        guard   <= 2'd2;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end

      if (eval && blocked) begin
        pending <= 1'b1;
      end else if (do_eval) begin
        pending <= flip;
      end

      case (state)
        S_IDLE: begin
          if (btn_start) begin
            state   <= S_RUN;
            presc   <= '0;
            rate_q  <= rate_sel;
            running <= 1'b1;
          end else if (stop) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_RUN: begin
          if (btn_start) begin
            state   <= S_PAUSE;
            pending <= 1'b0;
            running <= 1'b0;
          end else if (stop) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (tick) begin
            presc  <= '0;
            rate_q <= rate_sel;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (btn_start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end else if (stop) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (btn_start) begin
            state   <= S_RUN;
            presc   <= '0;
            rate_q  <= rate_sel;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - directed self-checking bench for cnt_seq_ctrl
module tb_cnt_seq_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          btn_start;
  logic          btn_dir;
  logic          btn_step;
  logic [1:0]    mode;
  logic [1:0]    rate_sel;
  logic [CW-1:0] cnt_in;
  logic          cnt_enable;
  logic          cnt_u_d;
  logic          running;
  logic          done;
  logic          ud_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.MAX(15), .MIN(0), .BASE_DIV(4)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .btn_start  (btn_start),
    .btn_dir    (btn_dir),
    .btn_step   (btn_step),
    .mode       (mode),
    .rate_sel   (rate_sel),
    .cnt_in     (cnt_in),
    .cnt_enable (cnt_enable),
    .cnt_u_d    (cnt_u_d),
    .running    (running),
    .done       (done)
  );

  // Counter stand-in: 0..15 wrap counter that registers U_D one cycle late
  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_in <= '0;
      ud_q   <= 1'b0;
    end else begin
      ud_q <= cnt_u_d;
      if (cnt_enable) begin
        if (ud_q) cnt_in <= (cnt_in == 4'd0)  ? 4'd15 : cnt_in - 4'd1;
        else      cnt_in <= (cnt_in == 4'd15) ? 4'd0  : cnt_in + 4'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    btn_start = 1'b0;
    btn_dir   = 1'b0;
    btn_step  = 1'b0;
    mode      = 2'b00;
    rate_sel  = 2'd0;
    step(2);
    sys_rst_n = 1'b1;
    step(1);
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sys_rst_n = 1'b0;
    step(1);
    n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", cnt_enable); end
    n_tests++; if (cnt_u_d !== 1'b0) begin n_fail++; $display("FAIL reset_ud: got %b want 0", cnt_u_d); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    sys_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1);
      n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL idle_no_en: cycle %0d got %b want 0", c, cnt_enable); end
    end
  endtask

  task automatic test_wrap();
    logic exp_en;
    do_reset();
    press_start();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL wrap_running: got %b want 1", running); end
    for (int k = 1; k <= 17; k++) begin
      for (int c = 1; c <= 4; c++) begin
        step(1);
        exp_en = (c == 4);
        n_tests++; if (cnt_enable !== exp_en) begin n_fail++; $display("FAIL wrap_en: period %0d cycle %0d got %b want %b", k, c, cnt_enable, exp_en); end
      end
    end
    step(1);
    n_tests++; if (cnt_in !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", cnt_in); end
    n_tests++; if (cnt_u_d !== 1'b0) begin n_fail++; $display("FAIL wrap_ud: got %b want 0", cnt_u_d); end
  endtask

  task automatic test_bounce();
    logic exp_en;
    do_reset();
    mode = 2'b01;
    press_start();
    for (int k = 1; k <= 15; k++) begin
      for (int c = 1; c <= 4; c++) begin
        step(1);
        exp_en = (c == 4);
        n_tests++; if (cnt_enable !== exp_en) begin n_fail++; $display("FAIL bounce_up_en: period %0d cycle %0d got %b want %b", k, c, cnt_enable, exp_en); end
      end
    end
    step(4);
    n_tests++; if (cnt_in !== 4'd15) begin n_fail++; $display("FAIL bounce_top: got %0d want 15", cnt_in); end
    n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL bounce_limit_en: got %b want 0", cnt_enable); end
    n_tests++; if (cnt_u_d !== 1'b1) begin n_fail++; $display("FAIL bounce_flip: got %b want 1", cnt_u_d); end
    for (int c = 1; c <= 2; c++) begin
      step(1);
      n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL bounce_guard_en: cycle %0d got %b want 0", c, cnt_enable); end
    end
    step(1);
    n_tests++; if (cnt_enable !== 1'b1) begin n_fail++; $display("FAIL bounce_after_guard: got %b want 1", cnt_enable); end
    step(1);
    n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL bounce_no_double: got %b want 0", cnt_enable); end
    n_tests++; if (cnt_in !== 4'd14) begin n_fail++; $display("FAIL bounce_down: got %0d want 14", cnt_in); end
  endtask

  task automatic test_oneshot();
    do_reset();
    mode    = 2'b10;
    btn_dir = 1'b1;
    step(1);
    btn_dir = 1'b0;
    n_tests++; if (cnt_u_d !== 1'b1) begin n_fail++; $display("FAIL oneshot_dir: got %b want 1", cnt_u_d); end
    press_start();
    step(4);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL oneshot_done: got %b want 1", done); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL oneshot_running: got %b want 0", running); end
    n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL oneshot_limit_en: got %b want 0", cnt_enable); end
    for (int c = 0; c < 8; c++) begin
      step(1);
      n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_en: cycle %0d got %b want 0", c, cnt_enable); end
    end
    press_start();
    n_tests++; if (cnt_u_d !== 1'b0) begin n_fail++; $display("FAIL oneshot_restart_ud: got %b want 0", cnt_u_d); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL oneshot_restart_run: got %b want 1", running); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_restart_done: got %b want 0", done); end
    step(4);
    n_tests++; if (cnt_enable !== 1'b1) begin n_fail++; $display("FAIL oneshot_resume_en: got %b want 1", cnt_enable); end
    step(1);
    n_tests++; if (cnt_in !== 4'd1) begin n_fail++; $display("FAIL oneshot_resume_up: got %0d want 1", cnt_in); end
  endtask

  task automatic test_dir_guard();
    int n_en;
    do_reset();
    press_start();
    step(10);
    btn_dir = 1'b1;
    step(1);
    btn_dir = 1'b0;
    n_tests++; if (cnt_u_d !== 1'b1) begin n_fail++; $display("FAIL guard_dir: got %b want 1", cnt_u_d); end
    n_en = 0;
    for (int c = 0; c <= 3; c++) begin
      step(1);
      if (cnt_enable === 1'b1) n_en++;
      n_tests++; if (cnt_enable !== (c == 2)) begin n_fail++; $display("FAIL guard_en: cycle %0d got %b want %b", c, cnt_enable, (c == 2)); end
    end
    n_tests++; if (n_en !== 1) begin n_fail++; $display("FAIL guard_count: got %0d want 1", n_en); end
    n_tests++; if (cnt_in !== 4'd1) begin n_fail++; $display("FAIL guard_down: got %0d want 1", cnt_in); end
    step(1);
    n_tests++; if (cnt_enable !== 1'b1) begin n_fail++; $display("FAIL guard_next_tick: got %b want 1", cnt_enable); end
  endtask

  task automatic test_pause_rate();
    do_reset();
    rate_sel = 2'd2;
    press_start();
    step(9);
    press_start();
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running); end
    for (int c = 0; c < 20; c++) begin
      step(1);
      n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL pause_en: cycle %0d got %b want 0", c, cnt_enable); end
    end
    press_start();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", running); end
    for (int j = 1; j <= 7; j++) begin
      step(1);
      n_tests++; if (cnt_enable !== (j == 7)) begin n_fail++; $display("FAIL resume_en: cycle %0d got %b want %b", j, cnt_enable, (j == 7)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_start();
    step(10);
    btn_dir = 1'b1;
    step(1);
    btn_dir = 1'b0;
    step(1);
    #2 sys_rst_n = 1'b0;
    #1;
    n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b want 0", cnt_enable); end
    n_tests++; if (cnt_u_d !== 1'b0) begin n_fail++; $display("FAIL midrst_ud: got %b want 0", cnt_u_d); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL midrst_running: got %b want 0", running); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    step(2);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(1);
      n_tests++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: cycle %0d got %b want 0", c, cnt_enable); end
    end
    press_start();
    step(4);
    n_tests++; if (cnt_enable !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got %b want 1", cnt_enable); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    btn_start = 1'b0;
    btn_dir   = 1'b0;
    btn_step  = 1'b0;
    mode      = 2'b00;
    rate_sel  = 2'd0;
    test_reset();
    test_wrap();
    test_bounce();
    test_oneshot();
    test_dir_guard();
    test_pause_rate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Sequencing controller for the shared up/down wrap counter (`cnt_nb`).
- Turns single-cycle button pulses and mode/rate selects into a rate-limited `cnt_enable` strobe and a `cnt_u_d` direction.
- Watches the counter value to implement wrap, bounce (ping-pong) and one-shot (stop at limit) sequences.
- Sits between the button debouncers and the counter instance.

Parameters:
- MAX, 15, counter upper limit; must match the counter instance.
- MIN, 0, counter lower limit; must match the counter instance.
- BASE_DIV, 4, prescaler base period in clk cycles (>=3).
- CW, $clog2(MAX+1), counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- btn_start  in  1  single-cycle pulse: start/pause toggle.
- btn_dir  in  1  single-cycle pulse: toggle direction.
- btn_step  in  1  single-cycle pulse: single step (used only with the optional feature).
- mode  in  2  00 wrap, 01 bounce, 10 one-shot, 11 treated as wrap.
- rate_sel  in  2  tick period = BASE_DIV << rate_sel cycles.
- cnt_in  in  CW  current counter value.
- cnt_enable  out  1  one-cycle enable strobe to the counter.
- cnt_u_d  out  1  direction to the counter: 1 down, 0 up.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state IDLE; cnt_enable 0, cnt_u_d 0, running 0, done 0; prescaler 0; guard 0; pending 0.
- FSM states: IDLE, RUN, PAUSE, DONE. All transitions below are triggered by btn_start.
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - DONE -> RUN, with cnt_u_d inverted and guard started.
  - Entering RUN from IDLE or DONE clears the prescaler; from PAUSE the prescaler resumes at its held value.
- Prescaler:
  - Counts only in RUN.
  - Raises tick when it reaches (BASE_DIV<<rate_sel)-1, then returns to 0.
  - rate_sel is sampled on the wrap.
- Guard:
  - Any cnt_u_d change loads a 2-cycle guard, because the counter registers U_D one cycle late.
  - A tick arriving during the guard sets pending.
  - Pending is issued as cnt_enable on the first cycle the guard is 0.
  - Only one pending tick is held; further ticks are dropped.
- Tick evaluation (RUN, guard 0, on tick or pending):
  - wrap: cnt_enable=1 next cycle.
  - bounce, at limit in the current direction (cnt_in>=MAX going up, cnt_in<=MIN going down): flip cnt_u_d, start guard, set pending, no enable this tick.
  - bounce, otherwise: enable.
  - one-shot, at limit: go to DONE, no enable, done=1.
  - one-shot, otherwise: enable.
- Out-of-range cnt_in: >MAX treated as MAX, <MIN treated as MIN.
- cnt_enable is registered and exactly one cycle wide, never asserted on two consecutive cycles.
- btn_dir:
  - Accepted in any state: toggles cnt_u_d and starts guard.
  - Ignored in a cycle where a bounce flip occurs (bounce flip wins).
- Simultaneous btn_start and btn_dir: both take effect.
- PAUSE: no enables; pending cleared; guard still counts down.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no enable is emitted after reset release until btn_start.

Optional Feature:
- Macro: CNT_SEQ_CTRL_STEP_EN.
- Defined: a btn_step pulse in PAUSE or IDLE issues exactly one cnt_enable, using the same limit rules as a tick.
  - bounce: a step at a limit flips direction and the enable follows after the guard.
  - one-shot: a step at a limit enters DONE.
  - btn_step is ignored in RUN and DONE.
- Undefined: btn_step ignored everywhere; no step logic synthesised.

Test Plan:
- Wrap: reset, mode=00, rate_sel=0, btn_start -> cnt_enable pulse every 4 cycles; cnt_in 0..15 then 0; running=1.
- Bounce: mode=01, run until cnt_in=15 -> at that tick no enable, cnt_u_d goes 1, next enable at least 2 cycles later, cnt_in goes to 14.
- One-shot: mode=10, btn_dir (down) at cnt_in=0, btn_start -> first tick gives no enable, done=1.
  - Then btn_start -> cnt_u_d=0, RUN, counting resumes up.
- Direction guard: btn_dir in RUN 1 cycle before a tick -> enable deferred to the cycle after the guard clears; exactly one enable issued.
- Pause/rate: rate_sel=2 (period 16), btn_start at prescaler=9 -> no enables while paused; after resume, first enable after 7 more cycles.
- Reset mid-run: assert sys_rst_n low while cnt_enable is pending -> all outputs 0 immediately; no enable after release until btn_start.
